// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serializer.
// Bit timing is driven entirely by the shared baud_tick; tx, tx_done are registered.
module uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_tick,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          stop_cnt;
  logic          last_stop;
  logic          push;
  logic          pop;

  assign in_ready  = (fifo_count != CW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  // Pop only from the registered count, so a byte written into an empty FIFO waits for the next tick.
  assign pop       = baud_tick && (fifo_count != '0) &&
                     ((state == IDLE) || ((state == STOP) && last_stop));
  assign busy      = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end
          end
          START: begin
            state   <= DATA;
            bit_cnt <= '0;
            tx      <= shift[0];
            shift   <= {1'b0, shift[7:1]};
          end
          DATA: begin
            if (bit_cnt == 3'd7) begin
              state    <= STOP;
              stop_cnt <= '0;
              tx       <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end
          STOP: begin
            if (last_stop) begin
              tx_done <= 1'b1;
              // Chain straight into the next start bit when more bytes are queued.
              if (pop) begin
                shift <= mem[rd_ptr];
                state <= START;
                tx    <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one task per scenario, each comparing tx per baud tick
// against hand-computed frame bit strings (first tick is the most significant bit).
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_valid2 = 1'b0;
  logic       in_ready, tx, busy, tx_done;
  logic [2:0] fifo_count;
  logic       in_ready2, tx2, busy2, tx_done2;
  logic [2:0] fifo_count2;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int done_cnt2 = 0;
  bit tick_en = 1'b0;
  logic [63:0] cap_tx;
  logic [63:0] cap_done;

  uart_tx #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .tx(tx), .busy(busy),
    .tx_done(tx_done), .fifo_count(fifo_count)
  );

  uart_tx #(.FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .in_data(in_data),
    .in_valid(in_valid2), .in_ready(in_ready2), .tx(tx2), .busy(busy2),
    .tx_done(tx_done2), .fifo_count(fifo_count2)
  );

  initial forever #5 clk = ~clk;

  // baud_tick every 16 clk while enabled; left untouched while disabled
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        cnt = (cnt == 15) ? 0 : cnt + 1;
        baud_tick = (cnt == 15);
      end else begin
        cnt = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    if (tx_done)  done_cnt++;
    if (tx_done2) done_cnt2++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic ticks_off();
    @(negedge clk);
    tick_en = 1'b0;
    baud_tick = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    in_data = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Record tx and tx_done just after each of the next n baud ticks.
  task automatic capture(input int n, input bit sel);
    cap_tx = '0;
    cap_done = '0;
    for (int k = 0; k < n; k++) begin
      int w = 0;
      do begin
        @(posedge clk);
        w++;
      end while (!baud_tick && w < 64);
      if (!baud_tick) begin
        total++; bad++;
        $display("FAIL capture_timeout: got no baud tick within %0d clk, required a tick", w);
        return;
      end
      #1;
      cap_tx   = {cap_tx[62:0], (sel ? tx2 : tx)};
      cap_done = {cap_done[62:0], (sel ? tx_done2 : tx_done)};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b required 1", tx); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_tx_done: got %b required 0", tx_done); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d required 0", fifo_count); end
    total++; if (tx2 !== 1'b1) begin bad++; $display("FAIL reset_tx2: got %b required 1", tx2); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    ticks_off();
    done_cnt = 0;
    push(8'hA5);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d required 1", fifo_count); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b required 1", busy); end
    tick_en = 1'b1;
    capture(11, 1'b0);
    total++; if (cap_tx[10:0] !== 11'b01010010111) begin bad++; $display("FAIL single_bits: got %b required %b", cap_tx[10:0], 11'b01010010111); end
    total++; if (cap_done[10:0] !== 11'b00000000001) begin bad++; $display("FAIL single_done: got %b required %b", cap_done[10:0], 11'b00000000001); end
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b required 0", busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL single_done_width: got %b required 0", tx_done); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL single_done_count: got %0d required 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    ticks_off();
    done_cnt = 0;
    push(8'h55);
    push(8'h0F);
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL b2b_count: got %0d required 2", fifo_count); end
    tick_en = 1'b1;
    capture(21, 1'b0);
    total++; if (cap_tx[20:0] !== 21'b010101010101111000011) begin bad++; $display("FAIL b2b_bits: got %b required %b", cap_tx[20:0], 21'b010101010101111000011); end
    total++; if (cap_done[20:0] !== 21'b000000000010000000001) begin bad++; $display("FAIL b2b_done: got %b required %b", cap_done[20:0], 21'b000000000010000000001); end
    @(posedge clk);
    #1;
    total++; if (done_cnt !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d required 2", done_cnt); end
  endtask

  task automatic test_fifo_full();
    ticks_off();
    done_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      in_data = 8'(i);
      in_valid = 1'b1;
      total++; if (in_ready !== (i <= 4)) begin bad++; $display("FAIL full_ready_%0d: got %b required %b", i, in_ready, (i <= 4)); end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d required 4", fifo_count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b required 0", in_ready); end
    tick_en = 1'b1;
    capture(41, 1'b0);
    total++; if (cap_tx[40:0] !== 41'b0100000001_0010000001_0110000001_0001000001_1) begin
      bad++; $display("FAIL full_bits: got %b required %b", cap_tx[40:0], 41'b0100000001_0010000001_0110000001_0001000001_1);
    end
    @(posedge clk);
    #1;
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL full_drained: got %0d required 0", fifo_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy: got %b required 0", busy); end
    total++; if (done_cnt !== 4) begin bad++; $display("FAIL full_done_count: got %0d required 4", done_cnt); end
  endtask

  task automatic test_full_boundary();
    ticks_off();
    done_cnt = 0;
    push(8'h11); push(8'h12); push(8'h13); push(8'h14);
    @(negedge clk);
    in_data = 8'h99;
    in_valid = 1'b1;
    baud_tick = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bound_ready_full: got %b required 0", in_ready); end
    @(posedge clk);
    #1;
    total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL bound_count_pop: got %0d required 3", fifo_count); end
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL bound_start: got %b required 0", tx); end
    @(negedge clk);
    baud_tick = 1'b0;
    in_data = 8'h15;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bound_ready_after: got %b required 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL bound_count_push: got %0d required 4", fifo_count); end
    tick_en = 1'b1;
    capture(50, 1'b0);
    total++; if (cap_tx[49:0] !== 50'b100010001_0010010001_0110010001_0001010001_0101010001_1) begin
      bad++; $display("FAIL bound_bits: got %b required %b", cap_tx[49:0], 50'b100010001_0010010001_0110010001_0001010001_0101010001_1);
    end
    @(posedge clk);
    #1;
    total++; if (done_cnt !== 5) begin bad++; $display("FAIL bound_done_count: got %0d required 5", done_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    ticks_off();
    done_cnt = 0;
    push(8'hFF);
    tick_en = 1'b1;
    capture(5, 1'b0);
    total++; if (cap_tx[4:0] !== 5'b01111) begin bad++; $display("FAIL midrst_pre: got %b required 01111", cap_tx[4:0]); end
    push(8'h77);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL midrst_tx: got %b required 1", tx); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL midrst_count: got %0d required 0", fifo_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b required 1", in_ready); end
    repeat (20) @(posedge clk);
    #1;
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d required 0", done_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    ticks_off();
    push(8'h3C);
    tick_en = 1'b1;
    capture(11, 1'b0);
    total++; if (cap_tx[10:0] !== 11'b00011110011) begin bad++; $display("FAIL midrst_bits: got %b required %b", cap_tx[10:0], 11'b00011110011); end
    total++; if (cap_done[10:0] !== 11'b00000000001) begin bad++; $display("FAIL midrst_done: got %b required %b", cap_done[10:0], 11'b00000000001); end
    @(posedge clk);
    #1;
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL midrst_done_count: got %0d required 1", done_cnt); end
  endtask

  task automatic test_two_stop();
    ticks_off();
    done_cnt2 = 0;
    @(negedge clk);
    in_data = 8'h00;
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    total++; if (fifo_count2 !== 3'd1) begin bad++; $display("FAIL stop2_count: got %0d required 1", fifo_count2); end
    tick_en = 1'b1;
    capture(12, 1'b1);
    total++; if (cap_tx[11:0] !== 12'b000000000111) begin bad++; $display("FAIL stop2_bits: got %b required %b", cap_tx[11:0], 12'b000000000111); end
    total++; if (cap_done[11:0] !== 12'b000000000001) begin bad++; $display("FAIL stop2_done: got %b required %b", cap_done[11:0], 12'b000000000001); end
    @(posedge clk);
    #1;
    total++; if (done_cnt2 !== 1) begin bad++; $display("FAIL stop2_done_count: got %0d required 1", done_cnt2); end
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL stop2_busy: got %b required 0", busy2); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL stop2_other_count: got %0d required 0", fifo_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_full_boundary();
    test_reset_mid_frame();
    test_two_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
